// File: rtl/keypad_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared types and widths for the matrix-keypad scan controller.
//   state_e      : scan FSM states (SCAN, PRESS, RELEASE)
//   CODE_W/ROW_W/CNT_W : widths for the default keypad geometry
//   clog2_min1() : $clog2 that never returns 0, for sizing registers from
//                  per-instance parameters
// -----------------------------------------------------------------------------
package keypad_pkg;

  localparam int DIV_DEF      = 402;
  localparam int ROWS_DEF     = 4;
  localparam int COLS_DEF     = 4;
  localparam int DEBOUNCE_DEF = 4;

  localparam int CODE_W = $clog2(ROWS_DEF * COLS_DEF);
  localparam int ROW_W  = $clog2(ROWS_DEF);
  localparam int CNT_W  = $clog2(DEBOUNCE_DEF + 1);

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// keypad_scan_ctrl_if
// Key-code handshake between the scan controller and the register logic.
//   key_code  : accepted key, row*COLS+col
//   key_valid : key_code holds an unacknowledged key
//   key_ack   : consumer takes key_code this cycle
//   overflow  : sticky flag, a key was dropped while key_valid was high
// Modports: master = scan controller, slave = consumer.
// -----------------------------------------------------------------------------
interface keypad_scan_ctrl_if
  import keypad_pkg::*;
#(
  parameter int CODE_W = keypad_pkg::CODE_W
);

  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_ack;
  logic              overflow;

  modport master (
    output key_code,
    output key_valid,
    output overflow,
    input  key_ack
  );

  modport slave (
    input  key_code,
    input  key_valid,
    input  overflow,
    output key_ack
  );

endinterface

// File: rtl/keypad_scan_ctrl_tick.sv
// -----------------------------------------------------------------------------
// keypad_tick
// Free-running divider producing a one-cycle tick every DIV clocks.
//   clk_in : system clock
//   reset  : synchronous active-high reset (counter restarts at 0)
//   tick   : high for one cycle when the counter sits at DIV-1
// The first tick is consumed DIV edges after reset is released.
// -----------------------------------------------------------------------------
module keypad_tick
  import keypad_pkg::*;
#(
  parameter int DIV = DIV_DEF
)(
  input  logic clk_in,
  input  logic reset,
  output logic tick
);

  localparam int W_DIV = clog2_min1(DIV);

  logic [W_DIV-1:0] r_cnt;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_cnt == W_DIV'(DIV - 1)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == W_DIV'(DIV - 1));

endmodule

// File: rtl/keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_scan_ctrl
// Matrix-keypad scanner: steps an active-low row strobe on every divided
// tick, samples the synchronized columns, debounces press and release and
// hands accepted keys to the register side through a valid/ack handshake.
//   clk_in : system clock
//   reset  : synchronous active-high reset
//   row_o  : registered row drive, active-low, at most one bit low
//   col_i  : asynchronous active-low column sense
//   kif    : key_code / key_valid / key_ack / overflow handshake (master)
// -----------------------------------------------------------------------------
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int DIV      = DIV_DEF,
  parameter int ROWS     = ROWS_DEF,
  parameter int COLS     = COLS_DEF,
  parameter int DEBOUNCE = DEBOUNCE_DEF
)(
  input  logic                 clk_in,
  input  logic                 reset,
  output logic [ROWS-1:0]      row_o,
  input  logic [COLS-1:0]      col_i,
  keypad_scan_ctrl_if.master   kif
);

  localparam int W_CODE = clog2_min1(ROWS * COLS);
  localparam int W_ROW  = clog2_min1(ROWS);
  localparam int W_COL  = clog2_min1(COLS);
  localparam int W_CNT  = clog2_min1(DEBOUNCE + 1);

  logic              w_tick;

  logic [COLS-1:0]   r_col_p0;
  logic [COLS-1:0]   r_col_p1;
  logic [COLS-1:0]   w_low_vec;
  logic [W_COL-1:0]  w_low_idx;
  logic              w_any_low;
  logic              w_sel_low;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [W_ROW-1:0]  r_row;
  logic [W_ROW-1:0]  w_row_nxt;
  logic [W_ROW-1:0]  w_row_inc;
  logic [W_COL-1:0]  r_cidx;
  logic [W_COL-1:0]  w_cidx_nxt;
  logic [W_CNT-1:0]  r_cnt;
  logic [W_CNT-1:0]  w_cnt_nxt;
  logic              w_accept;
  logic [W_CODE-1:0] w_code;

  logic [ROWS-1:0]   r_row_o;
  logic [W_CODE-1:0] r_key_code;
  logic              r_key_valid;
  logic              r_overflow;

  keypad_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk_in (clk_in),
    .reset  (reset),
    .tick   (w_tick)
  );

  // Stage p0/p1: two-flop synchronizer on the asynchronous columns.
  // Idle (all ones) at reset so no phantom press is seen.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_col_p0 <= '1;
      r_col_p1 <= '1;
    end else begin
      r_col_p0 <= col_i;
      r_col_p1 <= r_col_p0;
    end
  end

  assign w_low_vec = ~r_col_p1;
  assign w_any_low = |w_low_vec;
  assign w_sel_low = w_low_vec[r_cidx];

  // Lowest-index low column wins; scanning downward leaves the smallest.
  always_comb begin
    w_low_idx = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (((w_low_vec >> i) & COLS'(1)) != '0) begin
        w_low_idx = W_COL'(i);
      end
    end
  end

  assign w_row_inc = (r_row == W_ROW'(ROWS - 1)) ? '0 : r_row + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_cidx_nxt  = r_cidx;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    if (w_tick) begin
      unique case (r_state)
        SCAN: begin
          if (w_any_low) begin
            w_cidx_nxt = w_low_idx;
            // With a one-sample debounce the first sighting already qualifies.
            if (DEBOUNCE <= 1) begin
              w_accept    = 1'b1;
              w_state_nxt = RELEASE;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = PRESS;
              w_cnt_nxt   = W_CNT'(1);
            end
          end else begin
            w_row_nxt = w_row_inc;
          end
        end
        PRESS: begin
          if (w_sel_low) begin
            if (r_cnt == W_CNT'(DEBOUNCE - 1)) begin
              w_accept    = 1'b1;
              w_state_nxt = RELEASE;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end else begin
            w_state_nxt = SCAN;
            w_row_nxt   = w_row_inc;
            w_cnt_nxt   = '0;
          end
        end
        RELEASE: begin
          if (!w_sel_low) begin
            if (r_cnt == W_CNT'(DEBOUNCE - 1)) begin
              w_state_nxt = SCAN;
              w_row_nxt   = w_row_inc;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end else begin
            // Any bounce back to low restarts the release count.
            w_cnt_nxt = '0;
          end
        end
        default: begin
          w_state_nxt = SCAN;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Column index of the accepting tick is w_cidx_nxt: in SCAN it is the
  // freshly captured column, elsewhere it equals r_cidx.
  assign w_code = W_CODE'(r_row) * W_CODE'(COLS) + W_CODE'(w_cidx_nxt);

  // Stage p2: FSM state and registered row strobe, driven from the next row
  // so the strobe moves on the cycle after the deciding tick.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state <= SCAN;
      r_row   <= '0;
      r_cidx  <= '0;
      r_cnt   <= '0;
      r_row_o <= '1;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_cidx  <= w_cidx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_row_o <= ~(ROWS'(1) << w_row_nxt);
    end
  end

  // Output handshake: an ack in the accepting cycle frees the slot for the
  // new key, otherwise a pending key blocks it and the drop is flagged.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (w_accept) begin
      if (r_key_valid && !kif.key_ack) begin
        r_overflow <= 1'b1;
      end else begin
        r_key_code  <= w_code;
        r_key_valid <= 1'b1;
      end
    end else if (kif.key_ack) begin
      r_key_valid <= 1'b0;
    end
  end

  assign row_o         = r_row_o;
  assign kif.key_code  = r_key_code;
  assign kif.key_valid = r_key_valid;
  assign kif.overflow  = r_overflow;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan_ctrl
// Bench for keypad_scan_ctrl with DIV=10, DEBOUNCE=3, 4x4 keypad. A keypad
// model turns a 16-bit "keys held" mask plus the row strobe into col_i; a
// tick-level reference model tracks the expected outputs every cycle.
// -----------------------------------------------------------------------------
module tb_keypad_scan_ctrl;

  localparam int DIV      = 10;
  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int DEBOUNCE = 3;

  localparam int MS_SCAN  = 0;
  localparam int MS_PRESS = 1;
  localparam int MS_REL   = 2;

  logic        clk;
  logic        reset;
  logic [3:0]  row_o;
  logic [3:0]  col_i;
  logic [15:0] keys;

  int n_checks;
  int n_errors;

  keypad_scan_ctrl_if #(.CODE_W(4)) kif ();

  keypad_scan_ctrl #(
    .DIV      (DIV),
    .ROWS     (ROWS),
    .COLS     (COLS),
    .DEBOUNCE (DEBOUNCE)
  ) dut (
    .clk_in (clk),
    .reset  (reset),
    .row_o  (row_o),
    .col_i  (col_i),
    .kif    (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Keypad: a held key pulls its column low while its row is strobed.
  always @(negedge clk) begin
    logic [3:0] c;
    c = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) begin
        if (!row_o[2'(r)] && keys[4'(r * 4 + k)]) c[2'(k)] = 1'b0;
      end
    end
    col_i = c;
  end

  // Reference model, advanced per clock edge; rules applied only on ticks.
  int         m_edges;
  int         m_phase;
  int         m_row;
  int         m_col;
  int         m_n;
  int         m_code;
  bit         m_valid;
  bit         m_ovf;
  bit         m_ready;
  logic [3:0] m_s0;
  logic [3:0] m_s1;
  logic [3:0] m_rowdrv;

  initial m_ready = 1'b0;

  always @(posedge clk) begin : ref_model
    logic [3:0] seen;
    bit         acc;
    int         acode;
    int         lo;
    if (reset) begin
      m_edges  = 0;
      m_phase  = MS_SCAN;
      m_row    = 0;
      m_col    = 0;
      m_n      = 0;
      m_code   = 0;
      m_valid  = 1'b0;
      m_ovf    = 1'b0;
      m_s0     = 4'hF;
      m_s1     = 4'hF;
      m_rowdrv = 4'hF;
      m_ready  = 1'b1;
    end else begin
      seen  = m_s1;
      m_s1  = m_s0;
      m_s0  = col_i;
      m_edges++;
      acc   = 1'b0;
      acode = 0;
      if (m_edges % DIV == 0) begin
        lo = -1;
        for (int c = COLS - 1; c >= 0; c--) if (!seen[2'(c)]) lo = c;
        if (m_phase == MS_SCAN) begin
          if (lo >= 0) begin
            m_col   = lo;
            m_n     = 1;
            m_phase = MS_PRESS;
            if (m_n >= DEBOUNCE) begin acc = 1'b1; m_phase = MS_REL; m_n = 0; end
          end else begin
            m_row = (m_row + 1) % ROWS;
          end
        end else if (m_phase == MS_PRESS) begin
          if (!seen[m_col[1:0]]) begin
            m_n++;
            if (m_n >= DEBOUNCE) begin acc = 1'b1; m_phase = MS_REL; m_n = 0; end
          end else begin
            m_phase = MS_SCAN;
            m_n     = 0;
            m_row   = (m_row + 1) % ROWS;
          end
        end else begin
          if (seen[m_col[1:0]]) m_n++; else m_n = 0;
          if (m_n >= DEBOUNCE) begin
            m_phase = MS_SCAN;
            m_n     = 0;
            m_row   = (m_row + 1) % ROWS;
          end
        end
        acode = m_row * COLS + m_col;
      end
      if (acc) begin
        if (m_valid && !kif.key_ack) m_ovf = 1'b1;
        else begin m_code = acode; m_valid = 1'b1; end
      end else if (kif.key_ack) begin
        m_valid = 1'b0;
      end
      m_rowdrv = 4'hF ^ (4'h1 << m_row);
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      check("model_row_o",     32'(row_o),         32'(m_rowdrv));
      check("model_key_valid", 32'(kif.key_valid), 32'(m_valid));
      check("model_key_code",  32'(kif.key_code),  32'(m_code));
      check("model_overflow",  32'(kif.overflow),  32'(m_ovf));
    end
  end

  // Return at the falling edge following the k-th edge since reset release.
  task automatic wait_edge(input int k);
    int guard;
    guard = 0;
    while (m_edges < k) begin
      @(negedge clk);
      guard++;
      if (guard > 5000) begin
        n_checks++;
        n_errors++;
        $display("FAIL wait_edge: timeout, edge %0d, wanted %0d", m_edges, k);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "timeout");
      end
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset       = 1'b1;
    keys        = '0;
    kif.key_ack = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [15:0] k;
    int          code;
    int          edge_n;
  } vec_t;

  vec_t vecs [7];
  int   hold;
  int   pick;

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    reset       = 1'b1;
    keys        = '0;
    col_i       = 4'hF;
    kif.key_ack = 1'b0;

    vecs[0] = '{16'h0001,  0, 30};
    vecs[1] = '{16'h0040,  6, 40};
    vecs[2] = '{16'h8000, 15, 60};
    vecs[3] = '{16'h0100,  8, 50};
    vecs[4] = '{16'h0A00,  9, 50};
    vecs[5] = '{16'h2000, 13, 60};
    vecs[6] = '{16'h0108,  3, 30};

    // Reset and idle scan
    repeat (2) @(negedge clk);
    check("rst_row_o", 32'(row_o), 32'hF);
    check("rst_valid", 32'(kif.key_valid), 32'h0);
    check("rst_code",  32'(kif.key_code), 32'h0);
    check("rst_ovf",   32'(kif.overflow), 32'h0);
    reset = 1'b0;
    wait_edge(1);  check("idle_row_e1",  32'(row_o), 32'hE);
    wait_edge(9);  check("idle_row_e9",  32'(row_o), 32'hE);
    wait_edge(10); check("idle_row_e10", 32'(row_o), 32'hD);
    wait_edge(20); check("idle_row_e20", 32'(row_o), 32'hB);
    wait_edge(30); check("idle_row_e30", 32'(row_o), 32'h7);
    wait_edge(40); check("idle_row_e40", 32'(row_o), 32'hE);
    check("idle_valid", 32'(kif.key_valid), 32'h0);

    // Clean press of row 2, col 1
    reset_dut();
    keys = 16'h0200;
    wait_edge(49); check("press_valid_pre", 32'(kif.key_valid), 32'h0);
    wait_edge(50);
    check("press_valid", 32'(kif.key_valid), 32'h1);
    check("press_code",  32'(kif.key_code), 32'h9);
    check("press_row",   32'(row_o), 32'hB);
    kif.key_ack = 1'b1;
    keys        = '0;
    wait_edge(51);
    kif.key_ack = 1'b0;
    check("ack_valid", 32'(kif.key_valid), 32'h0);
    wait_edge(79); check("release_row_hold", 32'(row_o), 32'hB);
    wait_edge(80); check("release_row_next", 32'(row_o), 32'h7);

    // Bounce: seen on a single tick only
    reset_dut();
    keys = 16'h0200;
    wait_edge(30);
    keys = '0;
    wait_edge(40);
    check("bounce_row",   32'(row_o), 32'h7);
    check("bounce_valid", 32'(kif.key_valid), 32'h0);
    wait_edge(60); check("bounce_valid_late", 32'(kif.key_valid), 32'h0);

    // Overflow: second key while the first is unacknowledged
    reset_dut();
    keys = 16'h0200;
    wait_edge(50);
    keys = 16'h0008;
    wait_edge(119); check("ovf_pre", 32'(kif.overflow), 32'h0);
    wait_edge(120);
    check("ovf_set",   32'(kif.overflow), 32'h1);
    check("ovf_code",  32'(kif.key_code), 32'h9);
    check("ovf_valid", 32'(kif.key_valid), 32'h1);
    kif.key_ack = 1'b1;
    wait_edge(121);
    kif.key_ack = 1'b0;
    check("ovf_ack_valid", 32'(kif.key_valid), 32'h0);
    check("ovf_sticky",    32'(kif.overflow), 32'h1);

    // Ack in the same cycle as the second accept
    reset_dut();
    keys = 16'h0200;
    wait_edge(50);
    keys = 16'h0008;
    wait_edge(119);
    kif.key_ack = 1'b1;
    wait_edge(120);
    kif.key_ack = 1'b0;
    check("coll_valid", 32'(kif.key_valid), 32'h1);
    check("coll_code",  32'(kif.key_code), 32'h3);
    check("coll_ovf",   32'(kif.overflow), 32'h0);
    wait_edge(121);
    check("coll_valid_hold", 32'(kif.key_valid), 32'h1);

    // Reset after the second debounce tick
    reset_dut();
    keys = 16'h0200;
    wait_edge(40);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_row",   32'(row_o), 32'hF);
    check("midrst_valid", 32'(kif.key_valid), 32'h0);
    check("midrst_ovf",   32'(kif.overflow), 32'h0);
    reset = 1'b0;
    wait_edge(1);  check("midrst_row0", 32'(row_o), 32'hE);
    wait_edge(10); check("midrst_row1", 32'(row_o), 32'hD);

    // Table of single/multi-key presses with known accept edge and code
    for (int i = 0; i < 7; i++) begin
      reset_dut();
      keys = vecs[i].k;
      wait_edge(vecs[i].edge_n - 1);
      check($sformatf("tbl%0d_valid_pre", i), 32'(kif.key_valid), 32'h0);
      wait_edge(vecs[i].edge_n);
      check($sformatf("tbl%0d_valid", i), 32'(kif.key_valid), 32'h1);
      check($sformatf("tbl%0d_code", i),  32'(kif.key_code), 32'(vecs[i].code));
      kif.key_ack = 1'b1;
      keys        = '0;
      @(negedge clk);
      kif.key_ack = 1'b0;
    end

    // Randomized traffic against the reference model
    reset_dut();
    hold = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (hold == 0) begin
        pick = int'($urandom_range(0, 3));
        if (pick == 0)      keys = '0;
        else if (pick == 3) keys = 16'($urandom);
        else                keys = 16'(1 << $urandom_range(0, 15));
        hold = int'($urandom_range(5, 150));
      end else begin
        hold--;
      end
      kif.key_ack = ($urandom_range(0, 5) == 0);
      reset       = ($urandom_range(0, 2999) == 0);
    end
    @(negedge clk);
    reset       = 1'b0;
    kif.key_ack = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Matrix-keypad scan controller for the keyboard peripheral. It uses an internal divided tick to step an active-low row strobe across the keypad, samples the synchronized column lines, and debounces both press and release. Each accepted key is presented as a code with a valid/ack handshake to the Wishbone-side register logic.

## Interface
- DIV, 402: tick period in clk_in cycles (≥4)
- ROWS, 4: keypad rows
- COLS, 4: keypad columns
- DEBOUNCE, 4: consecutive tick samples needed to accept a press or release (≥1)
- clk_in  in  1  single system clock
- reset  in  1  synchronous, active-high reset
- row_o  out  ROWS  row drive, active-low, at most one bit low
- col_i  in  COLS  column sense, active-low, asynchronous
- key_code  out  $clog2(ROWS*COLS)  accepted key, row*COLS+col
- key_valid  out  1  key_code holds an unacknowledged key
- key_ack  in  1  consumer accepts key_code this cycle
- overflow  out  1  sticky: a key was dropped because key_valid was still high

## Operation
- col_i passes through a 2-flop synchronizer before any use; "col low" always means the synchronized value.
- Tick: single-cycle pulse every DIV cycles, driven by a free-running counter 0..DIV-1. The counter is never stalled by the FSM.
- FSM states and transitions (row r, column c, count n):
  - SCAN: drive row r. On tick, if any column is low, capture c as the lowest-index low column, set n=1, and go to PRESS. If n≥DEBOUNCE at that point, accept immediately. Otherwise set r=(r+1) mod ROWS.
  - PRESS: keep row r. On tick, if col c is low, n++; reaching DEBOUNCE accepts the key and goes to RELEASE with n=0. If col c is high, return to SCAN with r=(r+1) mod ROWS.
  - RELEASE: keep row r. On tick, col c high gives n++; col c low resets n=0. When n reaches DEBOUNCE, go to SCAN with r=(r+1) mod ROWS.
- Accept: key_code←r*COLS+c and key_valid←1 on the cycle after the accepting tick. If key_valid is already 1 and key_ack is 0 in the accepting cycle, the new key is dropped, key_code is unchanged, and overflow←1.
- Handshake: key_valid falls the cycle after key_ack=1. Ack and accept in the same cycle: the new key loads, key_valid stays 1, and overflow is not set. key_ack while key_valid=0 is ignored.
- overflow clears only on reset.
- Other columns pressed on the same row during PRESS/RELEASE are ignored. Multi-key detection is out of scope.

## Timing
- Reset values: row_o=all ones, key_valid=0, key_code=0, overflow=0, FSM=SCAN, r=0, n=0, tick counter=0, synchronizer flops=all ones.
- row_o is registered. The first cycle after reset deasserts, row_o=~1 (row 0 low). Row changes take effect the cycle after the deciding tick.
- The first tick occurs DIV cycles after reset deasserts. After that, ticks come every DIV cycles.
- col_i must be stable ≥3 cycles before a tick to be seen at that tick (2 sync flops plus sample).
- Press latency, once the strobe reaches the key's row: DEBOUNCE ticks, plus 1 cycle to key_valid.
- Reset asserted mid-PRESS or mid-RELEASE returns every output to its reset value on the next edge. Any pending key_valid is lost.

## Structure
- Package keypad_pkg holds the FSM state typedef (SCAN, PRESS, RELEASE) and the localparam widths CODE_W=$clog2(ROWS*COLS), ROW_W=$clog2(ROWS), CNT_W=$clog2(DEBOUNCE+1).
- One sub-module, keypad_tick (param DIV; ports clk_in, reset, tick), generates the divided tick. The FSM, synchronizer and handshake stay in keypad_scan_ctrl.

## Test plan
All scenarios use DIV=10, DEBOUNCE=3, ROWS=COLS=4.
- Reset and idle scan: row_o=4'hF during reset, 4'hE the first cycle after, then D, B, 7, E, each lasting 10 cycles. key_valid stays 0 throughout.
- Clean press: hold col_i[1] low whenever row 2 is driven. key_valid=1 and key_code=9 one cycle after the 3rd tick on row 2. Pulse key_ack; key_valid=0 the next cycle. Row stays 4'hB until 3 released ticks.
- Bounce: col_i[1] low for one tick on row 2, then high. No key_valid; the next row driven is 4'h7.
- Overflow: accept code 9, then without ack release and press row 0 col 3. key_code stays 9 and overflow=1.
- Ack collides with accept: assert key_ack exactly in the accepting cycle of a second key (code 3). key_valid stays 1, key_code=3, overflow=0.
- Reset mid-PRESS: assert reset after the 2nd debounce tick. Next cycle row_o=4'hF, key_valid=0, overflow=0. Scan restarts at row 0.
